// File: rtl/handshaking_receiver.sv
// handshaking_receiver
//   Receiving end of a valid/ready word handshake. Incoming words are stored in a
//   DEPTH-entry FIFO. The head word is presented first-word-fall-through to a local
//   consumer. ready_out drops only when the FIFO is full.
//
//   Optional feature macro: HS_RX_STATS_EN (adds xfer_count / stall_count).
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   data_in      in   write data from master
//   valid_in     in   master has data
//   ready_out    out  receiver can accept (registered, = !full)
//   rd_en        in   consumer pops head word
//   rd_data      out  head word, 0 when empty
//   rd_valid     out  FIFO non-empty (registered)
//   level        out  entries held, 0..DEPTH
//   xfer_count   out  (HS_RX_STATS_EN) accepted pushes, wrapping
//   stall_count  out  (HS_RX_STATS_EN) valid_in && !ready_out cycles, saturating
module handshaking_receiver #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4,
    localparam int unsigned PW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [PW:0]           level
`ifdef HS_RX_STATS_EN
    ,
    output logic [15:0]           xfer_count,
    output logic [15:0]           stall_count
`endif
);

    typedef enum logic [1:0] {StEmpty, StPartial, StFull} state_t;

    localparam logic [PW:0] LevelAlmostFull = (PW+1)'(DEPTH - 1);
    localparam logic [PW:0] LevelOne        = (PW+1)'(1);

    state_t                state;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Handshake qualifiers use registered flags only, so there is no combinational
    // path from valid_in to ready_out or from rd_en to rd_valid.
    logic push;
    logic pop;
    assign push = valid_in && ready_out;
    assign pop  = rd_en && rd_valid;

    // Storage is not reset; stale contents are masked by rd_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    assign rd_data = rd_valid ? mem[rd_ptr] : '0;

    // Occupancy FSM with registered ready_out / rd_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StEmpty;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            ready_out <= 1'b0;
            rd_valid  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            unique case (state)
                StEmpty: begin
                    // Also raises ready_out on the first edge after reset release.
                    ready_out <= 1'b1;
                    if (push) begin
                        state    <= StPartial;
                        level    <= LevelOne;
                        rd_valid <= 1'b1;
                    end
                end
                StPartial: begin
                    if (push && !pop) begin
                        level <= level + LevelOne;
                        if (level == LevelAlmostFull) begin
                            state     <= StFull;
                            ready_out <= 1'b0;
                        end
                    end else if (pop && !push) begin
                        level <= level - LevelOne;
                        if (level == LevelOne) begin
                            state    <= StEmpty;
                            rd_valid <= 1'b0;
                        end
                    end
                end
                StFull: begin
                    if (pop) begin
                        state     <= StPartial;
                        level     <= level - LevelOne;
                        ready_out <= 1'b1;
                    end
                end
                default: begin
                    state     <= StEmpty;
                    level     <= '0;
                    ready_out <= 1'b0;
                    rd_valid  <= 1'b0;
                end
            endcase
        end
    end

`ifdef HS_RX_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_count  <= '0;
            stall_count <= '0;
        end else begin
            if (push) xfer_count <= xfer_count + 16'd1;
            if (valid_in && !ready_out && stall_count != 16'hFFFF) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end
`endif

endmodule
